// File: rtl/alu_bitop_seq_if.sv
// ALU control-field encodings and the bundled decoder/ALU signal interface
// used by the CB-prefix BIT/RES/SET sequencer.
package alu_bitop_pkg;

    // Output-enable selects
    localparam logic [1:0] RES_OE = 2'd0;
    localparam logic [1:0] BS_OE  = 2'd1;
    localparam logic [1:0] SH_OE  = 2'd2;

    // Shifter mode
    localparam logic [1:0] NO_SH  = 2'd0;

    // Latch load controls
    localparam logic       NO_LD  = 1'b0;
    localparam logic       BUS_LD = 1'b1;

    // Op kinds; 3 is reserved and behaves as BIT
    localparam logic [1:0] KIND_BIT = 2'd0;
    localparam logic [1:0] KIND_RES = 2'd1;
    localparam logic [1:0] KIND_SET = 2'd2;

endpackage

interface alu_bitop_seq_if;

    // Decoder request side
    logic       start;
    logic [1:0] kind;
    logic [2:0] bitsel;
    logic [7:0] operand;

    // Decoder response side
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       wb_en;
    logic       carry_err;

    // ALU control word
    logic [2:0] alu_bs;
    logic [7:0] alu_op;
    logic [1:0] alu_sh;
    logic [1:0] alu_oe;
    logic       alu_la;
    logic       alu_lb;
    logic       alu_r;
    logic       alu_s;
    logic       alu_v;
    logic       alu_ne;
    logic       alu_ci;
    logic       alu_l;
    logic       alu_h;

    // ALU status back into the sequencer
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;

    // Environment: decoder plus ALU core
    modport master (
        output start, kind, bitsel, operand,
        output alu_result, alu_zero, alu_carry,
        input  ready, done, result, zero, wb_en, carry_err,
        input  alu_bs, alu_op, alu_sh, alu_oe, alu_la, alu_lb,
        input  alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h
    );

    // The sequencer itself
    modport slave (
        input  start, kind, bitsel, operand,
        input  alu_result, alu_zero, alu_carry,
        output ready, done, result, zero, wb_en, carry_err,
        output alu_bs, alu_op, alu_sh, alu_oe, alu_la, alu_lb,
        output alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h
    );

endinterface

// File: rtl/alu_bitop_seq.sv
// Sequencer for CB-prefixed BIT/RES/SET: walks the ALU through a three-cycle
// control-word program, samples result/zero at the end of T3 and pulses done.
module alu_bitop_seq
    import alu_bitop_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    alu_bitop_seq_if.slave io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StT3,
        StDone
    } state_t;

    typedef struct packed {
        logic [2:0] bs;
        logic [7:0] op;
        logic [1:0] sh;
        logic [1:0] oe;
        logic       la;
        logic       lb;
        logic       r;
        logic       s;
        logic       v;
        logic       ne;
        logic       ci;
        logic       l;
        logic       h;
    } ctl_t;

    localparam ctl_t CtlIdle = '{
        bs: 3'd0, op: 8'd0, sh: NO_SH, oe: RES_OE, la: NO_LD, lb: NO_LD,
        r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
    };

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_kind;
    logic [2:0] r_bitsel;
    logic [7:0] r_operand;

    ctl_t       r_ctl;
    ctl_t       w_ctl_nxt;

    logic       r_ready;
    logic       r_done;
    logic [7:0] r_result;
    logic       r_zero;
    logic       r_wb_en;
    logic       r_carry_err;

    logic       w_accept;
    logic [2:0] w_bitsel_nxt;
    logic       w_is_set;
    logic       w_done_nxt;
    logic       w_carry_fail;

    assign w_accept     = io_bus.start & r_ready;
    // T1 word is built on the accept edge, so it needs the incoming bit index
    assign w_bitsel_nxt = w_accept ? io_bus.bitsel : r_bitsel;
    assign w_is_set     = (r_kind == KIND_SET);
    assign w_done_nxt   = (r_state == StT3);
    assign w_carry_fail = ((r_state == StT2) || (r_state == StT3)) && !w_is_set &&
                          !io_bus.alu_carry;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StT1;
            StT1:    w_state_nxt = StT2;
            StT2:    w_state_nxt = StT3;
            StT3:    w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Control word is computed from the next state so it lines up with the state register
    always_comb begin
        w_ctl_nxt = CtlIdle;
        unique case (w_state_nxt)
            StT1: begin
                w_ctl_nxt.bs = w_bitsel_nxt;
                w_ctl_nxt.oe = BS_OE;
                w_ctl_nxt.lb = BUS_LD;
                w_ctl_nxt.la = NO_LD;
            end
            StT2, StT3: begin
                if (w_is_set) begin
                    w_ctl_nxt.r  = 1'b1;
                    w_ctl_nxt.s  = 1'b1;
                    w_ctl_nxt.v  = 1'b1;
                    w_ctl_nxt.ne = 1'b0;
                    w_ctl_nxt.ci = 1'b0;
                end else begin
                    w_ctl_nxt.r  = 1'b0;
                    w_ctl_nxt.s  = 1'b1;
                    w_ctl_nxt.v  = 1'b0;
                    w_ctl_nxt.ne = 1'b1;
                    w_ctl_nxt.ci = 1'b1;
                end
                if (w_state_nxt == StT2) begin
                    w_ctl_nxt.op = r_operand;
                    w_ctl_nxt.sh = NO_SH;
                    w_ctl_nxt.oe = SH_OE;
                    w_ctl_nxt.la = BUS_LD;
                    w_ctl_nxt.lb = NO_LD;
                    w_ctl_nxt.l  = 1'b1;
                    w_ctl_nxt.h  = 1'b0;
                end else begin
                    w_ctl_nxt.oe = RES_OE;
                    w_ctl_nxt.la = NO_LD;
                    w_ctl_nxt.lb = NO_LD;
                    w_ctl_nxt.l  = 1'b0;
                    w_ctl_nxt.h  = 1'b1;
                end
            end
            default: w_ctl_nxt = CtlIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_kind      <= KIND_BIT;
            r_bitsel    <= 3'd0;
            r_operand   <= 8'd0;
            r_ctl       <= CtlIdle;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_result    <= 8'd0;
            r_zero      <= 1'b0;
            r_wb_en     <= 1'b0;
            r_carry_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_kind    <= io_bus.kind;
                r_bitsel  <= io_bus.bitsel;
                r_operand <= io_bus.operand;
            end
            r_ctl   <= w_ctl_nxt;
            r_ready <= (w_state_nxt == StIdle);
            r_done  <= w_done_nxt;
            r_wb_en <= w_done_nxt && ((r_kind == KIND_RES) || (r_kind == KIND_SET));
            if (w_done_nxt) begin
                r_result <= io_bus.alu_result;
                r_zero   <= io_bus.alu_zero;
            end
            if (w_carry_fail) begin
                r_carry_err <= 1'b1;
            end
        end
    end

    assign io_bus.ready     = r_ready;
    assign io_bus.done      = r_done;
    assign io_bus.result    = r_result;
    assign io_bus.zero      = r_zero;
    assign io_bus.wb_en     = r_wb_en;
    assign io_bus.carry_err = r_carry_err;

    assign io_bus.alu_bs = r_ctl.bs;
    assign io_bus.alu_op = r_ctl.op;
    assign io_bus.alu_sh = r_ctl.sh;
    assign io_bus.alu_oe = r_ctl.oe;
    assign io_bus.alu_la = r_ctl.la;
    assign io_bus.alu_lb = r_ctl.lb;
    assign io_bus.alu_r  = r_ctl.r;
    assign io_bus.alu_s  = r_ctl.s;
    assign io_bus.alu_v  = r_ctl.v;
    assign io_bus.alu_ne = r_ctl.ne;
    assign io_bus.alu_ci = r_ctl.ci;
    assign io_bus.alu_l  = r_ctl.l;
    assign io_bus.alu_h  = r_ctl.h;

endmodule

// File: tb/tb_alu_bitop_seq.sv
// Bench for alu_bitop_seq: ALU stub, phase-level reference model, per-cycle
// comparison plus directed literal checks and randomized ops.
module tb_alu_bitop_seq;
    import alu_bitop_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_bitop_seq_if bus ();

    alu_bitop_seq dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- ALU stub ----------------
    logic [7:0] lat_a = 8'd0;
    logic [2:0] lat_b = 3'd0;
    logic       force_c0 = 1'b0;
    logic [7:0] stub_res;
    logic [7:0] stub_mask;

    always @(posedge clk) begin
        if (bus.alu_la) lat_a <= bus.alu_op;
        if (bus.alu_lb) lat_b <= bus.alu_bs;
    end

    // ---------------- reference model ----------------
    int         m_phase = 0;   // 0 idle, 1..3 = T1..T3, 4 = done cycle
    logic [1:0] m_kind = 2'd0;
    logic [2:0] m_b = 3'd0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_result = 8'd0;
    logic       m_zero = 1'b0;
    logic       m_cerr = 1'b0;
    int         accepts = 0;

    function automatic logic [7:0] spec_result(input logic [1:0] k, input logic [2:0] b,
                                               input logic [7:0] a);
        logic [7:0] m;
        m = 8'd1 << b;
        case (k)
            KIND_RES: return a & ~m;
            KIND_SET: return a | m;
            default:  return a & m;
        endcase
    endfunction

    // Stub returns the arithmetic answer only while the T3 word is on the bus
    always_comb begin
        stub_mask = 8'd1 << lat_b;
        stub_res  = 8'h5A;
        if (bus.alu_oe == RES_OE && bus.alu_h) begin
            if (bus.alu_r)              stub_res = lat_a | stub_mask;
            else if (m_kind == KIND_RES) stub_res = lat_a & ~stub_mask;
            else                         stub_res = lat_a & stub_mask;
        end
    end

    assign bus.alu_result = stub_res;
    assign bus.alu_zero   = (stub_res == 8'h00);
    assign bus.alu_carry  = !(force_c0 && bus.alu_oe == SH_OE);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_kind   <= KIND_BIT;
            m_result <= 8'd0;
            m_zero   <= 1'b0;
            m_cerr   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase <= 1;
                    m_kind  <= bus.kind;
                    m_b     <= bus.bitsel;
                    m_a     <= bus.operand;
                    accepts <= accepts + 1;
                end
                1: m_phase <= 2;
                2: begin
                    m_phase <= 3;
                    if (force_c0 && m_kind != KIND_SET) m_cerr <= 1'b1;
                end
                3: begin
                    m_phase  <= 4;
                    m_result <= spec_result(m_kind, m_b, m_a);
                    m_zero   <= (spec_result(m_kind, m_b, m_a) == 8'h00);
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // {ready,done,result,zero,wb_en,carry_err,bs,op,sh,oe,la,lb,r,s,v,ne,ci,l,h}
    function automatic logic [36:0] exp_vec();
        logic [2:0] bs;
        logic [7:0] op;
        logic [1:0] oe;
        logic       la, lb, r, s, v, ne, ci, l, h, wb;
        bs = 3'd0; op = 8'd0; oe = RES_OE; la = NO_LD; lb = NO_LD;
        r = 0; s = 0; v = 0; ne = 0; ci = 0; l = 0; h = 0;
        if (m_phase == 2 || m_phase == 3) begin
            if (m_kind == KIND_SET) begin r = 1; s = 1; v = 1; end
            else begin s = 1; ne = 1; ci = 1; end
        end
        if (m_phase == 1) begin bs = m_b; oe = BS_OE; lb = BUS_LD; end
        if (m_phase == 2) begin op = m_a; oe = SH_OE; la = BUS_LD; l = 1; end
        if (m_phase == 3) h = 1;
        wb = (m_phase == 4) && (m_kind == KIND_RES || m_kind == KIND_SET);
        return {m_phase == 0, m_phase == 4, m_result, m_zero, wb, m_cerr,
                bs, op, NO_SH, oe, la, lb, r, s, v, ne, ci, l, h};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {bus.ready, bus.done, bus.result, bus.zero, bus.wb_en, bus.carry_err,
                bus.alu_bs, bus.alu_op, bus.alu_sh, bus.alu_oe, bus.alu_la, bus.alu_lb,
                bus.alu_r, bus.alu_s, bus.alu_v, bus.alu_ne, bus.alu_ci, bus.alu_l,
                bus.alu_h};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_outputs", {27'd0, dut_vec()}, {27'd0, exp_vec()});
        end
    end

    // ---------------- stimulus ----------------
    int         lat;
    logic       t2_ne, t2_la;

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 64'(bus.ready), 64'd1);
    endtask

    task automatic run_op(input logic [1:0] k, input logic [2:0] b, input logic [7:0] a);
        wait_ready();
        bus.start   = 1'b1;
        bus.kind    = k;
        bus.bitsel  = b;
        bus.operand = a;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                t2_ne = bus.alu_ne;
                t2_la = bus.alu_la;
            end
        end
        if (!bus.done) chk("done_timeout", 64'(bus.done), 64'd1);
    endtask

    initial begin
        int a0;
        int dones;
        bus.start = 1'b0; bus.kind = 2'd0; bus.bitsel = 3'd0; bus.operand = 8'd0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_oe", 64'(bus.alu_oe), 64'(RES_OE));
        chk("rst_la", 64'(bus.alu_la), 64'(NO_LD));
        rst = 1'b0;
        @(negedge clk);

        run_op(KIND_RES, 3'd3, 8'hFF);
        chk("res3_latency", 64'(lat), 64'd4);
        chk("res3_result", 64'(bus.result), 64'hF7);
        chk("res3_zero", 64'(bus.zero), 64'd0);
        chk("res3_wb", 64'(bus.wb_en), 64'd1);
        chk("res3_cerr", 64'(bus.carry_err), 64'd0);

        run_op(KIND_RES, 3'd0, 8'h01);
        chk("res0_result", 64'(bus.result), 64'h00);
        chk("res0_zero", 64'(bus.zero), 64'd1);
        chk("res0_wb", 64'(bus.wb_en), 64'd1);

        run_op(KIND_SET, 3'd7, 8'h00);
        chk("set7_result", 64'(bus.result), 64'h80);
        chk("set7_zero", 64'(bus.zero), 64'd0);
        chk("set7_wb", 64'(bus.wb_en), 64'd1);
        chk("set7_t2_ne", 64'(t2_ne), 64'd0);
        chk("set7_t2_la", 64'(t2_la), 64'(BUS_LD));

        run_op(KIND_BIT, 3'd4, 8'hEF);
        chk("bit4_zero", 64'(bus.zero), 64'd1);
        chk("bit4_wb", 64'(bus.wb_en), 64'd0);
        chk("bit4_done", 64'(bus.done), 64'd1);
        run_op(KIND_BIT, 3'd4, 8'h10);
        chk("bit4b_zero", 64'(bus.zero), 64'd0);
        chk("bit4b_result", 64'(bus.result), 64'h10);

        // start held high with inputs churning every cycle
        wait_ready();
        a0 = accepts;
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.kind    = 2'($urandom_range(0, 3));
            bus.bitsel  = 3'($urandom);
            bus.operand = 8'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("held_accepts", 64'(accepts - a0), 64'd4);
        repeat (6) @(negedge clk);

        // reset pulse in T2
        wait_ready();
        bus.start = 1'b1; bus.kind = KIND_RES; bus.bitsel = 3'd1; bus.operand = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_in_t2", 64'(bus.alu_oe), 64'(SH_OE));
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(bus.ready), 64'd1);
        chk("midrst_oe", 64'(bus.alu_oe), 64'(RES_OE));
        chk("midrst_op", 64'(bus.alu_op), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done || bus.wb_en) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        run_op(KIND_RES, 3'd5, 8'hFF);
        chk("postrst_result", 64'(bus.result), 64'hDF);
        chk("postrst_latency", 64'(lat), 64'd4);

        // carry forced low in T2 of a RES op
        force_c0 = 1'b1;
        run_op(KIND_RES, 3'd2, 8'hFF);
        force_c0 = 1'b0;
        chk("cerr_set", 64'(bus.carry_err), 64'd1);
        chk("cerr_result", 64'(bus.result), 64'hFB);
        run_op(KIND_SET, 3'd1, 8'h00);
        chk("cerr_sticky", 64'(bus.carry_err), 64'd1);
        chk("cerr_set_result", 64'(bus.result), 64'h02);

        // randomized ops; per-cycle compare does the heavy lifting
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(2'($urandom_range(0, 3)), 3'($urandom), 8'($urandom));
            chk("rand_latency", 64'(lat), 64'd4);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
